pcs_sync: RTL and testbench

Code-group synchronization controller for the 1000BASE-X PCS receive path. Sits between the deserializer and the `reciever` block. It detects commas, tracks running disparity, and runs the acquire/lose-sync state machine. It drives the receiver's `sync_status`, `rx_even` and `SUDI`, plus a registered copy of the code group, all cycle-aligned.

---
 rtl/pcs_sync.sv | 168 ++++++++++++++++
 tb/tb_pcs_sync.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pcs_sync.sv
// 1000BASE-X PCS receive code-group synchronization: comma detect, running disparity, sync FSM.
// Optional PCS_SYNC_SIGDET_EN adds the signal_detect input gating sync and SUDI.
module pcs_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
`ifdef PCS_SYNC_SIGDET_EN
    input  logic       signal_detect,
`endif
    output logic [9:0] x_out,
    output logic       sync_status,
    output logic       rx_even,
    output logic       SUDI
);

    typedef enum logic [3:0] {
        LOSS_OF_SYNC,
        COMMA_DETECT_1,
        COMMA_DETECT_2,
        COMMA_DETECT_3,
        ACQUIRE_SYNC_1,
        ACQUIRE_SYNC_2,
        SYNC_ACQUIRED_1,
        SYNC_ACQUIRED_2,
        SYNC_ACQUIRED_3,
        SYNC_ACQUIRED_4,
        SYNC_ACQUIRED_2A,
        SYNC_ACQUIRED_3A,
        SYNC_ACQUIRED_4A
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] good_cgs_q, good_cgs_d;
    logic       rd_q, rd_d;
    logic       rx_even_q, rx_even_d;
    logic       sync_q, sync_d;
    logic       sudi_q;
    logic [9:0] x_q;

    logic [3:0] ones;
    logic       sd;
    logic       comma;
    logic       rd_err;
    logic       cgbad;
    logic       cggood;
    logic       data;

`ifdef PCS_SYNC_SIGDET_EN
    assign sd = signal_detect;
`else
    assign sd = 1'b1;
`endif

    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < 10; i++) ones = ones + {3'b000, x[i]};
    end

    assign comma  = (x[9:3] == 7'b0011111) || (x[9:3] == 7'b1100000);
    assign rd_err = ((ones == 4'd6) && rd_q) || ((ones == 4'd4) && !rd_q);
    // The next position is odd when the toggled rx_even would be 0.
    assign cgbad  = (ones < 4'd4) || (ones > 4'd6) || rd_err || (comma && rx_even_q);
    assign cggood = !cgbad;
    assign data   = cggood && !comma;

    always_comb begin
        state_d    = state_q;
        good_cgs_d = 2'd0;
        case (state_q)
            LOSS_OF_SYNC:   if (comma) state_d = COMMA_DETECT_1;
            COMMA_DETECT_1: state_d = data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
            COMMA_DETECT_2: state_d = data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
            COMMA_DETECT_3: state_d = data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1: begin
                if (cgbad)      state_d = LOSS_OF_SYNC;
                else if (comma) state_d = COMMA_DETECT_2;
            end
            ACQUIRE_SYNC_2: begin
                if (cgbad)      state_d = LOSS_OF_SYNC;
                else if (comma) state_d = COMMA_DETECT_3;
            end
            SYNC_ACQUIRED_1: if (cgbad) state_d = SYNC_ACQUIRED_2;
            SYNC_ACQUIRED_2: begin
                if (cgbad) state_d = SYNC_ACQUIRED_3;
                else begin
                    state_d    = SYNC_ACQUIRED_2A;
                    good_cgs_d = 2'd1;
                end
            end
            SYNC_ACQUIRED_3: begin
                if (cgbad) state_d = SYNC_ACQUIRED_4;
                else begin
                    state_d    = SYNC_ACQUIRED_3A;
                    good_cgs_d = 2'd1;
                end
            end
            SYNC_ACQUIRED_4: begin
                if (cgbad) state_d = LOSS_OF_SYNC;
                else begin
                    state_d    = SYNC_ACQUIRED_4A;
                    good_cgs_d = 2'd1;
                end
            end
            SYNC_ACQUIRED_2A: begin
                if (cgbad)                    state_d = SYNC_ACQUIRED_3;
                else if (good_cgs_q == 2'd3)  state_d = SYNC_ACQUIRED_1;
                else                          good_cgs_d = good_cgs_q + 2'd1;
            end
            SYNC_ACQUIRED_3A: begin
                if (cgbad)                    state_d = SYNC_ACQUIRED_4;
                else if (good_cgs_q == 2'd3)  state_d = SYNC_ACQUIRED_2;
                else                          good_cgs_d = good_cgs_q + 2'd1;
            end
            SYNC_ACQUIRED_4A: begin
                if (cgbad)                    state_d = LOSS_OF_SYNC;
                else if (good_cgs_q == 2'd3)  state_d = SYNC_ACQUIRED_3;
                else                          good_cgs_d = good_cgs_q + 2'd1;
            end
            default: state_d = LOSS_OF_SYNC;
        endcase

        if (!sd) begin
            state_d    = LOSS_OF_SYNC;
            good_cgs_d = 2'd0;
        end

        // A comma in LOSS_OF_SYNC has an unbalanced count, so this same rule reloads rd from it.
        rd_d = rd_q;
        if (ones > 4'd5)      rd_d = 1'b1;
        else if (ones < 4'd5) rd_d = 1'b0;

        rx_even_d = !rx_even_q;
        if (state_d == COMMA_DETECT_1 || state_d == COMMA_DETECT_2 ||
            state_d == COMMA_DETECT_3)
            rx_even_d = 1'b1;

        sync_d = (state_d == SYNC_ACQUIRED_1)  || (state_d == SYNC_ACQUIRED_2)  ||
                 (state_d == SYNC_ACQUIRED_3)  || (state_d == SYNC_ACQUIRED_4)  ||
                 (state_d == SYNC_ACQUIRED_2A) || (state_d == SYNC_ACQUIRED_3A) ||
                 (state_d == SYNC_ACQUIRED_4A);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LOSS_OF_SYNC;
            good_cgs_q <= 2'd0;
            rd_q       <= 1'b0;
            rx_even_q  <= 1'b0;
            sync_q     <= 1'b0;
            sudi_q     <= 1'b0;
            x_q        <= 10'h000;
        end else begin
            state_q    <= state_d;
            good_cgs_q <= good_cgs_d;
            rd_q       <= rd_d;
            rx_even_q  <= rx_even_d;
            sync_q     <= sync_d;
            sudi_q     <= sd;
            x_q        <= x;
        end
    end

    assign x_out       = x_q;
    assign sync_status = sync_q;
    assign rx_even     = rx_even_q;
    assign SUDI        = sudi_q;

endmodule

// File: tb/tb_pcs_sync.sv
// Randomized scoreboard bench for pcs_sync against a counter-based sync model.
module tb_pcs_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x;
    logic [9:0] x_out;
    logic       sync_status;
    logic       rx_even;
    logic       SUDI;
`ifdef PCS_SYNC_SIGDET_EN
    logic       signal_detect = 1'b1;
`endif

    always #5 clk = ~clk;

    pcs_sync dut (
        .clk(clk),
        .rst(rst),
        .x(x),
`ifdef PCS_SYNC_SIGDET_EN
        .signal_detect(signal_detect),
`endif
        .x_out(x_out),
        .sync_status(sync_status),
        .rx_even(rx_even),
        .SUDI(SUDI)
    );

    typedef struct packed {
        logic [9:0] xv;
        logic       sync;
        logic       even;
        logic       sudi;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: commas seen while acquiring, waiting-for-data flag, in-sync error level and good streak.
    bit m_sync, m_wait, m_rd, m_even;
    int m_commas, m_err, m_good;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync = 0; m_wait = 0; m_rd = 0; m_even = 0;
        m_commas = 0; m_err = 0; m_good = 0;
    endtask

    task automatic model_step(input logic [9:0] v, output exp_t e);
        int ones;
        bit comma, bad, data;
        ones  = $countones(v);
        comma = (v[9:3] == 7'b0011111) || (v[9:3] == 7'b1100000);
        bad   = (ones < 4) || (ones > 6) || (ones == 6 && m_rd) || (ones == 4 && !m_rd) ||
                (comma && m_even);
        data  = !bad && !comma;
        if (!m_sync) begin
            if (m_commas == 0) begin
                if (comma) begin m_commas = 1; m_wait = 1; end
            end else if (m_wait) begin
                m_wait = 0;
                if (!data) m_commas = 0;
                else if (m_commas == 3) begin
                    m_sync = 1; m_err = 0; m_good = 0; m_commas = 0;
                end
            end else begin
                if (bad) m_commas = 0;
                else if (comma) begin m_commas++; m_wait = 1; end
            end
        end else if (bad) begin
            m_good = 0;
            if (m_err == 3) begin m_sync = 0; m_err = 0; m_commas = 0; end
            else m_err++;
        end else if (m_err > 0) begin
            if (m_good == 3) begin m_err--; m_good = 0; end
            else m_good++;
        end
        m_even = m_wait ? 1'b1 : !m_even;
        if (ones > 5) m_rd = 1;
        else if (ones < 5) m_rd = 0;
        e.xv = v; e.sync = m_sync; e.even = m_even; e.sudi = 1'b1;
    endtask

    function automatic logic [9:0] k285();
        return m_rd ? 10'b1100000101 : 10'b0011111010;
    endfunction
    function automatic logic [9:0] d162();
        return m_rd ? 10'b1001000101 : 10'b0110110101;
    endfunction
    function automatic logic [9:0] idle();
        return m_even ? d162() : k285();
    endfunction
    function automatic logic [9:0] rderr();
        return m_rd ? 10'b1100011011 : 10'b1100010100;
    endfunction

    task automatic send(input logic [9:0] v);
        exp_t e;
        @(negedge clk);
        x = v;
        model_step(v, e);
        q.push_back(e);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send(idle());
    endtask

    task automatic send_random(input int n, input int idle_pct);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < idle_pct)      send(idle());
            else if (r < idle_pct + (100 - idle_pct) / 4)     send(10'h000);
            else if (r < idle_pct + (100 - idle_pct) / 2)     send(rderr());
            else if (r < idle_pct + 3 * (100 - idle_pct) / 4) send(10'($urandom));
            else                                              send(k285());
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".x_out"},       int'(x_out),       0);
        check({tag, ".sync_status"}, int'(sync_status), 0);
        check({tag, ".rx_even"},     int'(rx_even),     0);
        check({tag, ".SUDI"},        int'(SUDI),        0);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("x_out",       int'(x_out),       int'(e.xv));
            check("sync_status", int'(sync_status), int'(e.sync));
            check("rx_even",     int'(rx_even),     int'(e.even));
            check("SUDI",        int'(SUDI),        int'(e.sudi));
        end
    end

    initial begin
        rst = 1'b0;
        x   = 10'($urandom);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x = 10'($urandom);
            check_zero("in_reset");
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("after_release");

        // Acquire, loss, reacquire, recovery from two bad bursts.
        send_idle(12);
        repeat (4) send(10'h000);
        send_idle(12);
        repeat (2) send(10'h000);
        send_idle(8);
        repeat (3) send(10'h000);
        send_idle(10);

        // Force loss, then an odd-position comma during ACQUIRE_SYNC_1.
        repeat (6) send(10'h000);
        send_idle(2);
        send(d162());
        send(k285());
        send_idle(14);

        // Disparity errors separated by good code groups while in sync.
        send(rderr());
        send_idle(4);
        send(rderr());
        send_idle(3);
        send_idle(8);

        send_random(600, 90);

        // Asynchronous reset mid-frame.
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        x = 10'($urandom);
        @(posedge clk);
        #2;
        rst = 1'b1;
        send_idle(12);

        send_random(1200, 75);
        send_idle(20);

        @(posedge clk);
        @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
